// File: rtl/cmt_clkgen_ctrl.sv
// Run-time M/D reprogramming controller for DCM_CLKGEN with staggered BUFGCE re-enable.
// Latency: outputs registered, one cycle after the state decision; LOCKED seen after 2-flop sync.
// Backpressure: REQ_READY only in IDLE; CMT_CLKGEN_AUTOINIT_EN programs the defaults after reset.
module cmt_clkgen_ctrl #(
  parameter int NUM_CE      = 2,
  parameter int M_DEFAULT   = 30,
  parameter int D_DEFAULT   = 8,
  parameter int GATE_CYCLES = 4,
  parameter int STAGGER     = 16,
  parameter int TIMEOUT     = 65535,
  parameter int RST_CYCLES  = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [8:0]        REQ_M,
  input  logic [8:0]        REQ_D,
  output logic              PROGEN,
  output logic              PROGDATA,
  input  logic              PROGDONE,
  input  logic              LOCKED,
  output logic              DCM_RST,
  output logic [NUM_CE-1:0] CE,
  output logic              BUSY,
  output logic              ERR,
  output logic [8:0]        CUR_M,
  output logic [8:0]        CUR_D
);

  localparam int MAX_A  = (TIMEOUT > STAGGER) ? TIMEOUT : STAGGER;
  localparam int MAX_B  = (GATE_CYCLES > RST_CYCLES) ? GATE_CYCLES : RST_CYCLES;
  localparam int MAX_V  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW_RAW = $clog2(MAX_V) + 1;
  // The counter also indexes the 10-bit serial words, so never narrower than 4 bits.
  localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;

  typedef enum logic [3:0] {
    S_IDLE, S_GATE_OFF, S_LOAD_D, S_GAP1, S_LOAD_M, S_GAP2,
    S_GO, S_WAIT_DONE, S_WAIT_LOCK, S_DCM_RESET, S_UNGATE
  } state_t;

`ifdef CMT_CLKGEN_AUTOINIT_EN
  localparam state_t RST_STATE = S_GATE_OFF;
`else
  localparam state_t RST_STATE = S_WAIT_LOCK;
`endif

  state_t              state_q, state_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [4:0]          ch_q, ch_n;
  logic                lk_meta, lk;
  logic [8:0]          req_m_q, req_d_q;
  logic [7:0]          m_lo, d_lo;
  logic [9:0]          mw, dw;
  logic [NUM_CE-1:0]   ce_n;
  logic                err_n, progen_n, progdata_n, req_bad;

  assign m_lo = 8'(req_m_q - 9'd1);
  assign d_lo = 8'(req_d_q - 9'd1);
  assign dw   = {d_lo, 2'b01};
  assign mw   = {m_lo, 2'b11};
  assign req_bad = (REQ_M < 9'd2) || (REQ_M > 9'd256) || (REQ_D == 9'd0) || (REQ_D > 9'd256);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + 1'b1;
    ch_n    = ch_q;
    ce_n    = CE;
    err_n   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!lk) begin
          state_n = S_WAIT_LOCK;
          ce_n    = '0;
          err_n   = 1'b1;
        end else if (REQ_VALID && REQ_READY) begin
          if (req_bad) begin
            err_n = 1'b1;
          end else begin
            state_n = S_GATE_OFF;
            ce_n    = '0;
          end
        end
      end
      S_GATE_OFF:  if (cnt_q == CW'(GATE_CYCLES - 1)) state_n = S_LOAD_D;
      S_LOAD_D:    if (cnt_q == CW'(9)) state_n = S_GAP1;
      S_GAP1:      state_n = S_LOAD_M;
      S_LOAD_M:    if (cnt_q == CW'(9)) state_n = S_GAP2;
      S_GAP2:      state_n = S_GO;
      S_GO:        state_n = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (PROGDONE) begin
          state_n = S_WAIT_LOCK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_n = S_DCM_RESET;
          err_n   = 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          state_n = S_UNGATE;
          ce_n    = NUM_CE'(1);
          ch_n    = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_n = S_DCM_RESET;
          err_n   = 1'b1;
        end
      end
      S_DCM_RESET: if (cnt_q == CW'(RST_CYCLES - 1)) state_n = S_WAIT_LOCK;
      S_UNGATE: begin
        if (!lk) begin
          state_n = S_WAIT_LOCK;
          ce_n    = '0;
          err_n   = 1'b1;
        end else if (cnt_q == CW'(STAGGER - 1)) begin
          cnt_n = '0;
          if (ch_q == 5'(NUM_CE - 1)) begin
            state_n = S_IDLE;
          end else begin
            ch_n = ch_q + 5'd1;
            // Channels enable in index order, so shifting in a one sets the next gate.
            ce_n = (CE << 1) | NUM_CE'(1);
          end
        end
      end
      default: state_n = RST_STATE;
    endcase
    if (state_n != state_q) cnt_n = '0;

    progen_n   = (state_n == S_LOAD_D) || (state_n == S_LOAD_M) || (state_n == S_GO);
    progdata_n = 1'b0;
    if (state_n == S_LOAD_D) progdata_n = dw[cnt_n[3:0]];
    if (state_n == S_LOAD_M) progdata_n = mw[cnt_n[3:0]];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      ch_q      <= '0;
      lk_meta   <= 1'b0;
      lk        <= 1'b0;
      req_m_q   <= 9'(M_DEFAULT);
      req_d_q   <= 9'(D_DEFAULT);
      CE        <= '0;
      PROGEN    <= 1'b0;
      PROGDATA  <= 1'b0;
      DCM_RST   <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b1;
      REQ_READY <= 1'b0;
      CUR_M     <= 9'(M_DEFAULT);
      CUR_D     <= 9'(D_DEFAULT);
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      ch_q      <= ch_n;
      lk_meta   <= LOCKED;
      lk        <= lk_meta;
      CE        <= ce_n;
      PROGEN    <= progen_n;
      PROGDATA  <= progdata_n;
      DCM_RST   <= (state_n == S_DCM_RESET);
      ERR       <= err_n;
      BUSY      <= (state_n != S_IDLE);
      REQ_READY <= (state_n == S_IDLE);
      if (REQ_VALID && REQ_READY) begin
        req_m_q <= REQ_M;
        req_d_q <= REQ_D;
      end
      if (state_q == S_WAIT_DONE && PROGDONE) begin
        CUR_M <= req_m_q;
        CUR_D <= req_d_q;
      end
    end
  end

endmodule
